// File: rtl/quad_pkg.sv
// Shared types and sizing helpers for the quad counter readout scheduler.
package quad_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Channel word is {zl, i, c}: two W-bit counters plus the index latch bit.
    function automatic int quad_word_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int bytes_per_chan(input int w);
        return (2 * w + 1 + 7) / 8;
    endfunction

endpackage

// File: rtl/quad_byte_sel.sv
// Picks one zero-padded byte out of the captured channel words.
module quad_byte_sel
    import quad_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 14,
    localparam int QW   = quad_word_w(W),
    localparam int BPC  = bytes_per_chan(W),
    localparam int CH_W = (N > 1) ? $clog2(N) : 1,
    localparam int B_W  = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic [N-1:0][QW-1:0] shadow,
    input  logic [CH_W-1:0]      ch,
    input  logic [B_W-1:0]       b,
    output logic [7:0]           byte_out
);

    logic [8*BPC-1:0] padded;

    always_comb begin
        padded          = '0;
        padded[QW-1:0]  = shadow[ch];
        byte_out        = padded[8*b +: 8];
    end

endmodule

// File: rtl/quad_readout_seq.sv
// Snapshot-and-stream scheduler: captures all channel words at once, then
// hands them to the host one byte per read strobe, clearing reported index latches.
module quad_readout_seq
    import quad_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 14,
    localparam int QW = quad_word_w(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            snap,
    input  logic            rd,
    input  logic [N*QW-1:0] quad_in,
    output logic [7:0]      dout,
    output logic            dvalid,
    output logic [N-1:0]    zr,
    output logic            busy,
    output logic            done
);

    localparam int BPC   = bytes_per_chan(W);
    localparam int NB    = N * BPC;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CH_W  = (N > 1) ? $clog2(N) : 1;
    localparam int B_W   = (BPC > 1) ? $clog2(BPC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB - 1);
    localparam logic [B_W-1:0]   LAST_BYTE = B_W'(BPC - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N-1:0][QW-1:0] shadow_q;

    logic                 capture;
    logic                 issue;
    logic                 last_issue;
    logic [CH_W-1:0]      ch;
    logic [B_W-1:0]       b;
    logic [7:0]           sel_byte;
    logic [N-1:0]         zr_d;

    always_comb begin
        ch = CH_W'(int'(idx_q) / BPC);
        b  = B_W'(int'(idx_q) % BPC);
    end

    quad_byte_sel #(
        .N (N),
        .W (W)
    ) u_byte_sel (
        .shadow   (shadow_q),
        .ch       (ch),
        .b        (b),
        .byte_out (sel_byte)
    );

    // snap outranks rd in every state, so a coincident strobe is simply dropped.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        capture    = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        if (snap) begin
            capture = 1'b1;
            idx_d   = '0;
            state_d = STREAM;
        end else if (state_q == STREAM && rd) begin
            issue = 1'b1;
            if (idx_q == LAST_IDX) begin
                last_issue = 1'b1;
                idx_d      = '0;
                state_d    = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Latch clear goes out only with the byte that actually carries zl.
    always_comb begin
        zr_d = '0;
        for (int k = 0; k < N; k++) begin
            zr_d[k] = issue && (b == LAST_BYTE) && (int'(ch) == k) && shadow_q[k][QW-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            dout     <= '0;
            dvalid   <= 1'b0;
            zr       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                shadow_q <= quad_in;
            end
            if (issue) begin
                dout <= sel_byte;
            end
            dvalid <= issue;
            zr     <= zr_d;
            busy   <= (state_d == STREAM);
            done   <= last_issue;
        end
    end

endmodule
